disp_vramctrl: RTL and testbench

DISP_VRAMCTRL -- requirements
Module: disp_vramctrl

---
 rtl/disp_pkg.sv | 19 +
 rtl/disp_vramctrl.sv | 111 +++++++++++
 tb/tb_disp_vramctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared geometry and state encoding for the display VRAM fetch controller.
// Derived values assume 64-bit beats (two 32-bit pixels per word).
package disp_pkg;

    localparam int H_PIX            = 640;
    localparam int V_PIX            = 480;
    localparam int BURST_LEN        = 16;
    localparam int WORDS_PER_FRAME  = H_PIX * V_PIX / 2;
    localparam int BURSTS_PER_FRAME = WORDS_PER_FRAME / BURST_LEN;
    localparam int ADDR_STEP        = BURST_LEN * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITBUF = 2'd1,
        SETADDR = 2'd2,
        READ    = 2'd3
    } state_e;

endpackage

// File: rtl/disp_vramctrl.sv
// Fetches one frame of pixel pairs from VRAM over AXI read bursts and streams
// them into the display FIFO, one burst outstanding at a time.
module disp_vramctrl #(
    parameter int H_PIX     = disp_pkg::H_PIX,
    parameter int V_PIX     = disp_pkg::V_PIX,
    parameter int BURST_LEN = disp_pkg::BURST_LEN
) (
    input  logic        ACLK,
    input  logic        ARST_N,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    input  logic        VSTART,
    input  logic        BUF_WREADY,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic        BUSY
);

    localparam int          BURSTS     = H_PIX * V_PIX / 2 / BURST_LEN;
    localparam int          STEP       = BURST_LEN * 8;
    localparam int          SHIFT      = $clog2(STEP);
    localparam logic [13:0] LAST_BURST = 14'(BURSTS - 1);
    localparam logic [28:0] ALIGN_MASK = ~29'(STEP - 1);

    disp_pkg::state_e state_reg;
    logic [28:0]      base_reg;
    logic [13:0]      burst_cnt_reg;
    logic [31:0]      araddr_reg;
    logic             arvalid_reg;
    logic             rready_reg;
    logic             busy_reg;
    logic             beat_ok;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARADDR  = araddr_reg;
    assign ARVALID = arvalid_reg;
    assign RREADY  = rready_reg;
    assign BUSY    = busy_reg;

    // Beats pass straight through to the FIFO; stray RVALID outside READ is dropped.
    assign beat_ok = (state_reg == disp_pkg::READ) && RVALID;
    assign FIFOWR  = beat_ok;
    assign FIFOIN  = beat_ok ? RDATA : 64'd0;

    always_ff @(posedge ACLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_reg     <= disp_pkg::IDLE;
            base_reg      <= '0;
            burst_cnt_reg <= '0;
            araddr_reg    <= '0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                disp_pkg::IDLE: begin
                    if (VSTART && DISPON) begin
                        base_reg      <= DISPADDR & ALIGN_MASK;
                        burst_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= disp_pkg::WAITBUF;
                    end
                end
                disp_pkg::WAITBUF: begin
                    if (!DISPON) begin
                        busy_reg  <= 1'b0;
                        state_reg <= disp_pkg::IDLE;
                    end else if (BUF_WREADY) begin
                        araddr_reg  <= {3'b000, base_reg} + (32'(burst_cnt_reg) << SHIFT);
                        arvalid_reg <= 1'b1;
                        state_reg   <= disp_pkg::SETADDR;
                    end
                end
                disp_pkg::SETADDR: begin
                    // Once presented, the address is always followed through even if DISPON drops.
                    if (ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= disp_pkg::READ;
                    end
                end
                disp_pkg::READ: begin
                    if (RVALID && RLAST) begin
                        burst_cnt_reg <= burst_cnt_reg + 14'd1;
                        rready_reg    <= 1'b0;
                        if (burst_cnt_reg == LAST_BURST || !DISPON) begin
                            busy_reg  <= 1'b0;
                            state_reg <= disp_pkg::IDLE;
                        end else begin
                            state_reg <= disp_pkg::WAITBUF;
                        end
                    end
                end
                default: state_reg <= disp_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_vramctrl.sv
// Directed bench for disp_vramctrl: behavioural AXI read slave plus per-feature tests.
// Frame height is reduced to 4 lines (80 bursts) to keep the full-frame run short.
`timescale 1ns/1ps
module tb_disp_vramctrl;

    localparam int TB_V_PIX  = 4;
    localparam int TB_BURSTS = 80;

    logic        ACLK = 1'b0;
    logic        ARST_N = 1'b0;
    logic        DISPON = 1'b0;
    logic [28:0] DISPADDR = '0;
    logic        VSTART = 1'b0;
    logic        BUF_WREADY = 1'b0;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [63:0] RDATA = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    disp_vramctrl #(.H_PIX(640), .V_PIX(TB_V_PIX), .BURST_LEN(16)) dut (
        .ACLK(ACLK), .ARST_N(ARST_N), .DISPON(DISPON), .DISPADDR(DISPADDR),
        .VSTART(VSTART), .BUF_WREADY(BUF_WREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .FIFOIN(FIFOIN), .FIFOWR(FIFOWR), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    // Slave knobs and monitor records
    int          ar_delay = 0;
    bit          rv_toggle = 0;
    bit          rv_garbage = 0;
    logic [31:0] ar_q[$];
    int          ar_cyc_q[$];
    int          cyc = 0;
    bit          pending = 0, rv_phase = 0, arv_prev = 0, hs_prev = 0, exp_wr;
    int          beats = 0, writes = 0, ar_wait = 0;
    int          bursts_done = 0, bad_burst_len = 0, fifowr_total = 0, fifoin_bad = 0;
    int          proto_bad = 0, ar_unstable = 0, arvalid_pending = 0, arvalid_cycles = 0;
    logic [31:0] cur_addr = '0, addr_prev = '0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Drive slave inputs at the falling edge, then record what the next rising edge will see.
    always @(negedge ACLK) begin
        if (!ARST_N) begin
            pending = 0; beats = 0; writes = 0; ar_wait = 0; rv_phase = 0;
            arv_prev = 0; hs_prev = 0;
            ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
        end else begin
            ARREADY = ARVALID && (ar_wait >= ar_delay);
            if (pending) begin
                rv_phase = !rv_phase;
                RVALID   = !rv_toggle || rv_phase;
                RDATA    = {cur_addr, 16'hA5C3, 8'h00, 8'(beats)};
                RLAST    = (beats == 15);
            end else begin
                RVALID = rv_garbage;
                RLAST  = rv_garbage;
                RDATA  = 64'hDEAD_BEEF_0BAD_F00D;
            end
            #1;
            if (ARST_N) begin
                if (arv_prev && !hs_prev && (ARVALID !== 1'b1 || ARADDR !== addr_prev)) ar_unstable++;
                if (ARVALID === 1'b1 && !arv_prev) ar_cyc_q.push_back(cyc);
                exp_wr = pending && RVALID;
                if (RREADY !== pending) proto_bad++;
                if (FIFOWR !== exp_wr) proto_bad++;
                if (FIFOWR === 1'b1 && FIFOIN !== RDATA) fifoin_bad++;
                if (exp_wr) begin
                    fifowr_total++; writes++; beats++;
                    if (RLAST) begin
                        pending = 0;
                        bursts_done++;
                        if (writes != 16) bad_burst_len++;
                    end
                end
                hs_prev = 0;
                if (ARVALID === 1'b1) begin
                    arvalid_cycles++;
                    if (pending) arvalid_pending++;
                    if (ARREADY) begin
                        ar_q.push_back(ARADDR);
                        cur_addr = ARADDR; pending = 1; beats = 0; writes = 0;
                        ar_wait = 0; rv_phase = 0; hs_prev = 1;
                    end else begin
                        ar_wait++;
                    end
                end
                arv_prev  = (ARVALID === 1'b1);
                addr_prev = ARADDR;
            end
        end
    end

    task automatic tick();
        @(negedge ACLK);
        #2;
    endtask

    task automatic pulse_vstart();
        VSTART = 1'b1;
        tick();
        VSTART = 1'b0;
    endtask

    task automatic clear_logs();
        ar_q.delete(); ar_cyc_q.delete();
        bursts_done = 0; bad_burst_len = 0; fifowr_total = 0; fifoin_bad = 0;
        proto_bad = 0; ar_unstable = 0; arvalid_pending = 0; arvalid_cycles = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin tick(); n++; end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL %s idle timeout: BUSY=%b expected 0", name, BUSY); end
    endtask

    task automatic test_reset();
        ARST_N = 1'b0;
        repeat (3) tick();
        checks++; if ({ARVALID, RREADY, FIFOWR, BUSY} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b expected 0000", {ARVALID, RREADY, FIFOWR, BUSY}); end
        checks++; if (ARADDR !== 32'd0) begin errors++; $display("FAIL reset_araddr got %h expected 0", ARADDR); end
        checks++; if (FIFOIN !== 64'd0) begin errors++; $display("FAIL reset_fifoin got %h expected 0", FIFOIN); end
        checks++; if ({ARLEN, ARSIZE, ARBURST} !== {8'd15, 3'b011, 2'b01}) begin errors++; $display("FAIL static_ar got %h/%h/%h expected 0f/3/1", ARLEN, ARSIZE, ARBURST); end
        ARST_N = 1'b1;
        rv_garbage = 1;
        repeat (2) tick();
        checks++; if (FIFOWR !== 1'b0 || FIFOIN !== 64'd0 || RVALID !== 1'b1) begin errors++; $display("FAIL idle_stray_rvalid FIFOWR=%b FIFOIN=%h expected 0/0", FIFOWR, FIFOIN); end
    endtask

    task automatic test_vstart_disabled();
        clear_logs();
        DISPON = 1'b0; DISPADDR = 29'h0100_0000;
        pulse_vstart();
        repeat (3) tick();
        checks++; if (BUSY !== 1'b0 || arvalid_cycles != 0) begin errors++; $display("FAIL vstart_dispon0 BUSY=%b arvalid=%0d expected 0/0", BUSY, arvalid_cycles); end
    endtask

    task automatic test_basic_fetch();
        int bad = 0;
        clear_logs();
        DISPADDR = 29'h0100_0000; DISPON = 1'b1; BUF_WREADY = 1'b1; rv_garbage = 1;
        pulse_vstart();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", BUSY); end
        wait_idle("basic", 3000);
        checks++; if (ar_q.size() != TB_BURSTS) begin errors++; $display("FAIL basic_nbursts got %0d expected %0d", ar_q.size(), TB_BURSTS); end
        if (ar_q.size() >= 2) begin
            checks++; if (ar_q[0] !== 32'h0100_0000) begin errors++; $display("FAIL basic_addr0 got %h expected 01000000", ar_q[0]); end
            checks++; if (ar_q[1] !== 32'h0100_0080) begin errors++; $display("FAIL basic_addr1 got %h expected 01000080", ar_q[1]); end
            checks++; if (ar_q[ar_q.size()-1] !== 32'h0100_2780) begin errors++; $display("FAIL basic_addr_last got %h expected 01002780", ar_q[ar_q.size()-1]); end
        end
        foreach (ar_q[i]) if (ar_q[i] !== 32'h0100_0000 + 32'(i) * 32'd128) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_addr_seq got %0d wrong expected 0", bad); end
        checks++; if (fifowr_total != TB_BURSTS * 16) begin errors++; $display("FAIL basic_fifowr got %0d expected %0d", fifowr_total, TB_BURSTS * 16); end
        checks++; if (bad_burst_len != 0) begin errors++; $display("FAIL basic_burst_len got %0d bad expected 0", bad_burst_len); end
        checks++; if (fifoin_bad != 0 || proto_bad != 0) begin errors++; $display("FAIL basic_data got %0d/%0d expected 0/0", fifoin_bad, proto_bad); end
        checks++; if (arvalid_pending != 0 || arvalid_cycles != TB_BURSTS) begin errors++; $display("FAIL basic_arvalid got %0d/%0d expected 0/%0d", arvalid_pending, arvalid_cycles, TB_BURSTS); end
    endtask

    task automatic test_vstart_busy();
        int n = 0, bad = 0;
        clear_logs();
        DISPADDR = 29'h0020_0000; DISPON = 1'b1; BUF_WREADY = 1'b1;
        pulse_vstart();
        while (ar_q.size() < 5 && n < 500) begin tick(); n++; end
        DISPADDR = 29'h0030_0000;
        pulse_vstart();
        while (ar_q.size() < 8 && n < 1000) begin tick(); n++; end
        DISPON = 1'b0;
        wait_idle("vstart_busy", 100);
        checks++; if (ar_q.size() != 8) begin errors++; $display("FAIL vstart_busy_nbursts got %0d expected 8", ar_q.size()); end
        foreach (ar_q[i]) if (ar_q[i] !== 32'h0020_0000 + 32'(i) * 32'd128) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL vstart_busy_seq got %0d wrong expected 0", bad); end
    endtask

    task automatic test_backpressure();
        int n = 0, arvc, t;
        clear_logs();
        DISPADDR = 29'h0040_0000; DISPON = 1'b1; BUF_WREADY = 1'b1;
        pulse_vstart();
        while (ar_q.size() < 3 && n < 200) begin tick(); n++; end
        BUF_WREADY = 1'b0;
        while (bursts_done < 3 && n < 400) begin tick(); n++; end
        arvc = arvalid_cycles;
        repeat (50) tick();
        checks++; if (arvalid_cycles != arvc || ar_q.size() != 3 || BUSY !== 1'b1) begin errors++; $display("FAIL bp_hold arvalid %0d->%0d bursts %0d BUSY=%b expected no change/3/1", arvc, arvalid_cycles, ar_q.size(), BUSY); end
        BUF_WREADY = 1'b1;
        t = cyc;
        n = 0;
        while (ar_q.size() < 4 && n < 20) begin tick(); n++; end
        checks++; if (ar_q.size() < 4) begin errors++; $display("FAIL bp_resume got %0d bursts expected 4", ar_q.size()); end
        else begin
            checks++; if (ar_q[3] !== 32'h0040_0180) begin errors++; $display("FAIL bp_addr got %h expected 00400180", ar_q[3]); end
            checks++; if (ar_cyc_q[3] - t != 1) begin errors++; $display("FAIL bp_latency got %0d expected 1", ar_cyc_q[3] - t); end
        end
        DISPON = 1'b0;
        wait_idle("bp", 100);
        checks++; if (fifowr_total != 64) begin errors++; $display("FAIL bp_fifowr got %0d expected 64", fifowr_total); end
    endtask

    task automatic test_stall();
        int n = 0;
        clear_logs();
        ar_delay = 5; rv_toggle = 1; rv_garbage = 0;
        DISPADDR = 29'h0050_0000; DISPON = 1'b1; BUF_WREADY = 1'b1;
        pulse_vstart();
        while (ar_q.size() < 1 && n < 30) begin tick(); n++; end
        DISPON = 1'b0;
        wait_idle("stall", 100);
        checks++; if (arvalid_cycles != 6 || ar_unstable != 0) begin errors++; $display("FAIL stall_ar cycles=%0d unstable=%0d expected 6/0", arvalid_cycles, ar_unstable); end
        checks++; if (ar_q.size() != 1 || (ar_q.size() == 1 && ar_q[0] !== 32'h0050_0000)) begin errors++; $display("FAIL stall_addr n=%0d expected 1 at 00500000", ar_q.size()); end
        checks++; if (fifowr_total != 16 || bursts_done != 1) begin errors++; $display("FAIL stall_fifowr got %0d/%0d expected 16/1", fifowr_total, bursts_done); end
        checks++; if (fifoin_bad != 0 || proto_bad != 0) begin errors++; $display("FAIL stall_data got %0d/%0d expected 0/0", fifoin_bad, proto_bad); end
        ar_delay = 0; rv_toggle = 0; rv_garbage = 1;
    endtask

    task automatic test_dispon_drop();
        int n = 0, arvc;
        clear_logs();
        DISPADDR = 29'h0060_0000; DISPON = 1'b1; BUF_WREADY = 1'b1;
        pulse_vstart();
        while (!(ar_q.size() == 10 && beats == 7) && n < 400) begin tick(); n++; end
        DISPON = 1'b0;
        wait_idle("dispon_drop", 100);
        checks++; if (ar_q.size() != 10 || bursts_done != 10) begin errors++; $display("FAIL drop_bursts got %0d/%0d expected 10/10", ar_q.size(), bursts_done); end
        checks++; if (fifowr_total != 160 || bad_burst_len != 0) begin errors++; $display("FAIL drop_fifowr got %0d bad=%0d expected 160/0", fifowr_total, bad_burst_len); end
        arvc = arvalid_cycles;
        repeat (20) tick();
        checks++; if (arvalid_cycles != arvc) begin errors++; $display("FAIL drop_quiet arvalid %0d expected %0d", arvalid_cycles, arvc); end
        clear_logs();
        DISPON = 1'b1;
        pulse_vstart();
        n = 0;
        while (ar_q.size() < 1 && n < 20) begin tick(); n++; end
        checks++; if (ar_q.size() < 1 || ar_q[0] !== 32'h0060_0000) begin errors++; $display("FAIL drop_restart n=%0d expected first addr 00600000", ar_q.size()); end
        DISPON = 1'b0;
        wait_idle("drop_restart", 100);
    endtask

    task automatic test_dispon_waitbuf();
        clear_logs();
        DISPADDR = 29'h0070_0000; DISPON = 1'b1; BUF_WREADY = 1'b0;
        pulse_vstart();
        tick();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL waitbuf_busy got %b expected 1", BUSY); end
        DISPON = 1'b0;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL waitbuf_exit got %b expected 0", BUSY); end
        BUF_WREADY = 1'b1;
        repeat (5) tick();
        checks++; if (arvalid_cycles != 0) begin errors++; $display("FAIL waitbuf_noaddr got %0d expected 0", arvalid_cycles); end
    endtask

    task automatic test_reset_midburst();
        int n = 0;
        clear_logs();
        DISPADDR = 29'h0000_0047; DISPON = 1'b1; BUF_WREADY = 1'b1;
        pulse_vstart();
        while (!(ar_q.size() >= 1 && beats >= 4) && n < 50) begin tick(); n++; end
        checks++; if (ar_q.size() < 1 || ar_q[0] !== 32'd0) begin errors++; $display("FAIL unaligned_addr n=%0d expected first addr 00000000", ar_q.size()); end
        checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL midburst_rready got %b expected 1", RREADY); end
        ARST_N = 1'b0;
        #1;
        checks++; if ({ARVALID, RREADY, FIFOWR, BUSY} !== 4'b0 || FIFOIN !== 64'd0 || ARADDR !== 32'd0) begin errors++; $display("FAIL async_reset ctl=%b FIFOIN=%h ARADDR=%h expected 0", {ARVALID, RREADY, FIFOWR, BUSY}, FIFOIN, ARADDR); end
        repeat (2) tick();
        ARST_N = 1'b1;
        repeat (2) tick();
        checks++; if (BUSY !== 1'b0 || RREADY !== 1'b0) begin errors++; $display("FAIL post_reset BUSY=%b RREADY=%b expected 0/0", BUSY, RREADY); end
        DISPON = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vstart_disabled();
        test_basic_fetch();
        test_vstart_busy();
        test_backpressure();
        test_stall();
        test_dispon_drop();
        test_dispon_waitbuf();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
